// File: rtl/load_unit.sv
// Load-side data-memory access unit: issues a word-aligned read, waits under a timeout,
// then extracts and sign/zero-extends the addressed byte, half or word.
module load_unit #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [2:0]  req_funct3,
  output logic        mem_re,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_rdata,
  input  logic        mem_rvalid,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic [1:0]  rsp_err,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  state_t        state, state_d;
  logic [31:0]   addr_q, addr_d;
  logic [2:0]    f3_q, f3_d;
  logic [CW-1:0] cnt, cnt_d;
  logic [31:0]   data_q, data_d;
  logic [1:0]    err_q, err_d;

  logic [7:0]    byte_sel;
  logic [15:0]   half_sel;
  logic [31:0]   ext;
  logic          illegal, misal;

  always_comb begin
    byte_sel = mem_rdata[7:0];
    case (addr_q[1:0])
      2'd1:    byte_sel = mem_rdata[15:8];
      2'd2:    byte_sel = mem_rdata[23:16];
      2'd3:    byte_sel = mem_rdata[31:24];
      default: byte_sel = mem_rdata[7:0];
    endcase
    half_sel = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (f3_q)
      3'b000:  ext = {{24{byte_sel[7]}}, byte_sel};
      3'b001:  ext = {{16{half_sel[15]}}, half_sel};
      3'b100:  ext = {24'h0, byte_sel};
      3'b101:  ext = {16'h0, half_sel};
      default: ext = mem_rdata;
    endcase
  end

  always_comb begin
    case (req_funct3)
      3'b000, 3'b001, 3'b010, 3'b100, 3'b101: illegal = 1'b0;
      default:                                illegal = 1'b1;
    endcase
    misal = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
            ((req_funct3 == 3'b010) && (req_addr[1:0] != 2'b00));
  end

  always_comb begin
    state_d = state;
    addr_d  = addr_q;
    f3_d    = f3_q;
    cnt_d   = cnt;
    data_d  = data_q;
    err_d   = err_q;
    case (state)
      IDLE: begin
        if (req_valid) begin
          addr_d = req_addr;
          f3_d   = req_funct3;
          cnt_d  = '0;
          data_d = '0;
          // illegal funct3 outranks misalignment; neither touches memory
          if (illegal) begin
            err_d   = 2'b11;
            state_d = RESP;
          end else if (misal) begin
            err_d   = 2'b01;
            state_d = RESP;
          end else begin
            err_d   = 2'b00;
            state_d = REQ;
          end
        end
      end
      REQ, WAIT: begin
        if (mem_rvalid) begin
          data_d  = ext;
          err_d   = 2'b00;
          state_d = RESP;
        end else if (cnt == CW'(TIMEOUT - 1)) begin
          cnt_d   = cnt + 1'b1;
          data_d  = '0;
          err_d   = 2'b10;
          state_d = RESP;
        end else begin
          cnt_d   = cnt + 1'b1;
          state_d = WAIT;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          data_d  = '0;
          err_d   = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      addr_q <= '0;
      f3_q   <= '0;
      cnt    <= '0;
      data_q <= '0;
      err_q  <= '0;
    end else begin
      state  <= state_d;
      addr_q <= addr_d;
      f3_q   <= f3_d;
      cnt    <= cnt_d;
      data_q <= data_d;
      err_q  <= err_d;
    end
  end

  assign req_ready = (state == IDLE) && rst_n;
  assign mem_re    = (state == REQ);
  assign mem_addr  = mem_re ? {addr_q[31:2], 2'b00} : '0;
  assign rsp_valid = (state == RESP);
  assign rsp_data  = data_q;
  assign rsp_err   = err_q;
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_load_unit.sv
// Directed bench for load_unit: extraction, error paths, wait states, timeout,
// response back-pressure and mid-access reset.
module tb_load_unit;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [2:0]  req_funct3;
  logic        mem_re;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata;
  logic        mem_rvalid;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic [1:0]  rsp_err;
  logic        busy;

  int n_cmp = 0;
  int n_err = 0;

  load_unit #(.TIMEOUT(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .req_funct3 (req_funct3),
    .mem_re     (mem_re),
    .mem_addr   (mem_addr),
    .mem_rdata  (mem_rdata),
    .mem_rvalid (mem_rvalid),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_data   (rsp_data),
    .rsp_err    (rsp_err),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // waits: wait states before mem_rvalid (-1 = never); hold: cycles rsp_ready stays low
  task automatic load(input string tag, input logic [31:0] a, input logic [2:0] f,
                      input logic [31:0] word, input int waits, input int hold,
                      input logic [31:0] exp_d, input logic [1:0] exp_e,
                      input int exp_lat, input int exp_pulses);
    int lat;
    int pulses;
    chk({tag, "_ready"}, {31'h0, req_ready}, 32'h1);
    req_valid  = 1'b1;
    req_addr   = a;
    req_funct3 = f;
    tick;
    req_valid = 1'b0;
    lat    = 1;
    pulses = 0;
    while (!rsp_valid && lat < 40) begin
      if (mem_re) begin
        pulses++;
        chk({tag, "_maddr"}, mem_addr, {a[31:2], 2'b00});
      end
      mem_rvalid = (waits >= 0) && (lat == 1 + waits);
      mem_rdata  = word;
      tick;
      mem_rvalid = 1'b0;
      lat++;
    end
    chk({tag, "_lat"}, lat, exp_lat);
    chk({tag, "_pulses"}, pulses, exp_pulses);
    chk({tag, "_data"}, rsp_data, exp_d);
    chk({tag, "_err"}, {30'h0, rsp_err}, {30'h0, exp_e});
    for (int i = 0; i < hold; i++) begin
      mem_rvalid = 1'b1;
      mem_rdata  = 32'hDEADBEEF;
      tick;
      mem_rvalid = 1'b0;
      chk({tag, "_hold_v"}, {31'h0, rsp_valid}, 32'h1);
      chk({tag, "_hold_d"}, rsp_data, exp_d);
      chk({tag, "_hold_e"}, {30'h0, rsp_err}, {30'h0, exp_e});
      chk({tag, "_hold_rdy"}, {31'h0, req_ready}, 32'h0);
      chk({tag, "_hold_busy"}, {31'h0, busy}, 32'h1);
    end
    rsp_ready = 1'b1;
    tick;
    rsp_ready = 1'b0;
    chk({tag, "_done_v"}, {31'h0, rsp_valid}, 32'h0);
    chk({tag, "_done_busy"}, {31'h0, busy}, 32'h0);
  endtask

  initial begin
    rst_n      = 1'b0;
    req_valid  = 1'b0;
    req_addr   = '0;
    req_funct3 = '0;
    mem_rdata  = '0;
    mem_rvalid = 1'b0;
    rsp_ready  = 1'b0;
    #1;
    chk("rst_mem_re", {31'h0, mem_re}, 32'h0);
    chk("rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_rsp_data", rsp_data, 32'h0);
    tick;
    tick;
    rst_n = 1'b1;
    tick;
    chk("rel_ready", {31'h0, req_ready}, 32'h1);
    chk("rel_mem_addr", mem_addr, 32'h0);
    chk("rel_err", {30'h0, rsp_err}, 32'h0);

    // zero-wait memory, word 0x8070F0FF at 0x100
    load("lb101",  32'h101, 3'b000, 32'h8070F0FF, 0, 0, 32'hFFFFFFF0, 2'b00, 2, 1);
    load("lbu103", 32'h103, 3'b100, 32'h8070F0FF, 0, 0, 32'h00000080, 2'b00, 2, 1);
    load("lh102",  32'h102, 3'b001, 32'h8070F0FF, 0, 0, 32'hFFFF8070, 2'b00, 2, 1);
    load("lhu100", 32'h100, 3'b101, 32'h8070F0FF, 0, 0, 32'h0000F0FF, 2'b00, 2, 1);
    load("lw100",  32'h100, 3'b010, 32'h8070F0FF, 0, 0, 32'h8070F0FF, 2'b00, 2, 1);
    load("lbu100", 32'h100, 3'b100, 32'h8070F0FF, 0, 0, 32'h000000FF, 2'b00, 2, 1);
    load("lb102",  32'h102, 3'b000, 32'h8070F0FF, 0, 0, 32'h00000070, 2'b00, 2, 1);

    // error paths: no memory access, response one cycle after accept
    load("lw102",  32'h102, 3'b010, 32'h8070F0FF, 0, 0, 32'h0, 2'b01, 1, 0);
    load("lh101",  32'h101, 3'b001, 32'h8070F0FF, 0, 0, 32'h0, 2'b01, 1, 0);
    load("lhu103", 32'h103, 3'b101, 32'h8070F0FF, 0, 0, 32'h0, 2'b01, 1, 0);
    load("f3_011", 32'h100, 3'b011, 32'h8070F0FF, 0, 0, 32'h0, 2'b11, 1, 0);
    load("f3_111", 32'h103, 3'b111, 32'h8070F0FF, 0, 0, 32'h0, 2'b11, 1, 0);

    // three wait states
    load("lh_ws3", 32'h100, 3'b001, 32'h8070F0FF, 3, 0, 32'hFFFFF0FF, 2'b00, 5, 1);

    // timeout: 16 REQ/WAIT cycles, late mem_rvalid during RESP must not disturb it
    load("tmo", 32'h200, 3'b010, 32'h12345678, -1, 2, 32'h0, 2'b10, 17, 1);
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hCAFEF00D;
    tick;
    mem_rvalid = 1'b0;
    chk("stray_idle_v", {31'h0, rsp_valid}, 32'h0);
    chk("stray_idle_busy", {31'h0, busy}, 32'h0);
    load("after_tmo", 32'h200, 3'b010, 32'h12345678, 1, 0, 32'h12345678, 2'b00, 3, 1);

    // back-pressure: rsp_ready low for 5 cycles
    load("stall", 32'h103, 3'b000, 32'h8070F0FF, 0, 5, 32'hFFFFFF80, 2'b00, 2, 1);

    // reset in WAIT aborts the access
    req_valid  = 1'b1;
    req_addr   = 32'h100;
    req_funct3 = 3'b001;
    tick;
    req_valid = 1'b0;
    tick;
    tick;
    chk("pre_rst_busy", {31'h0, busy}, 32'h1);
    rst_n = 1'b0;
    #1;
    chk("arst_mem_re", {31'h0, mem_re}, 32'h0);
    chk("arst_mem_addr", mem_addr, 32'h0);
    chk("arst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    chk("arst_rsp_data", rsp_data, 32'h0);
    chk("arst_rsp_err", {30'h0, rsp_err}, 32'h0);
    chk("arst_busy", {31'h0, busy}, 32'h0);
    tick;
    rst_n      = 1'b1;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h8070F0FF;
    tick;
    mem_rvalid = 1'b0;
    chk("post_rst_v", {31'h0, rsp_valid}, 32'h0);
    chk("post_rst_busy", {31'h0, busy}, 32'h0);
    tick;
    chk("post_rst_v2", {31'h0, rsp_valid}, 32'h0);
    load("post_rst_lw", 32'h104, 3'b010, 32'hA5A55A5A, 0, 0, 32'hA5A55A5A, 2'b00, 2, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
